// File: rtl/dm_arb_pkg.sv
// Shared definitions for the two-port data-RAM arbiter.
//   PORT_CPU / PORT_AUX : read-tag encoding of the issuing port
//   WEN_W / DATA_W      : byte-enable and data widths of the RAM interface
//   STARVE_W            : width of the aux starvation counter
package dm_arb_pkg;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  localparam int unsigned WEN_W    = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STARVE_W = 4;

endpackage : dm_arb_pkg

// File: rtl/dm_arb_prio.sv
// Grant logic for the two-port arbiter: the CPU has fixed priority, and a
// starvation counter forces one aux grant after STARVE_LIMIT consecutive
// CPU wins over a pending aux request.
//   clk, rst            : clock, asynchronous active-high reset
//   cpu_req, aux_req    : port requests
//   cpu_gnt, aux_gnt    : combinational grants, mutually exclusive, low in reset
//   starve_cnt          : current starvation count (for observation)
module dm_arb_prio
  import dm_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4  // legal range 1..15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic                aux_req,
  output logic                cpu_gnt,
  output logic                aux_gnt,
  output logic [STARVE_W-1:0] starve_cnt
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the ifs can leave a signal unassigned and infer a latch.
  always_comb begin
    cpu_gnt = 1'b0;
    aux_gnt = 1'b0;
    // Grants are gated by rst so nothing reaches the RAM during reset.
    if (!rst) begin
      if (aux_req && (!cpu_req || starve_cnt_q == LIMIT)) begin
        aux_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end
    end
  end

  // The counter only measures an unbroken wait: any aux grant or any cycle
  // with aux idle restarts it. The saturation guard is belt-and-braces; at
  // the limit the override grants aux, which clears it anyway.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!aux_req || aux_gnt) begin
      starve_cnt_d = '0;
    end else if (cpu_gnt && starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign starve_cnt = starve_cnt_q;

endmodule : dm_arb_prio

// File: rtl/dm_port_arbiter.sv
// Two-port arbiter in front of the single-port, synchronous-read data RAM.
// Port 0 is the CPU memory stage, port 1 an auxiliary master (debug/DMA).
// At most one access is granted per cycle; the returning read word is
// steered to the issuing port one cycle after the grant.
//   clk, rst                              : clock, async active-high reset
//   cpu_req/wen/addr/wdata, cpu_gnt       : CPU request and grant
//   cpu_rvalid, cpu_rdata                 : CPU read response
//   aux_*                                 : same set for the aux port
//   ram_en/wen/addr/wdata, ram_rdata      : RAM interface (1-cycle read)
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cpu_req,
  input  logic [WEN_W-1:0]  cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              aux_req,
  input  logic [WEN_W-1:0]  aux_wen,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_rdata,

  output logic              ram_en,
  output logic [WEN_W-1:0]  ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic [STARVE_W-1:0] starve_cnt;

  logic rd_pend_q, rd_pend_d;
  logic rd_tag_q,  rd_tag_d;

  dm_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .aux_req    (aux_req),
    .cpu_gnt    (cpu_gnt),
    .aux_gnt    (aux_gnt),
    .starve_cnt (starve_cnt)
  );

  // RAM request mux; idle cycles drive zeros so the bus is quiet.
  always_comb begin
    ram_en    = cpu_gnt | aux_gnt;
    ram_wen   = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (cpu_gnt) begin
      ram_wen   = cpu_wen;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (aux_gnt) begin
      ram_wen   = aux_wen;
      ram_addr  = aux_addr;
      ram_wdata = aux_wdata;
    end
  end

  // A read is outstanding for exactly the cycle after its grant; the tag
  // only matters while rd_pend is set, so it simply holds otherwise.
  always_comb begin
    rd_pend_d = ram_en && (ram_wen == '0);
    rd_tag_d  = rd_tag_q;
    if (rd_pend_d) begin
      rd_tag_d = aux_gnt ? PORT_AUX : PORT_CPU;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q <= 1'b0;
      rd_tag_q  <= PORT_CPU;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
    end
  end

  assign cpu_rvalid = rd_pend_q && (rd_tag_q == PORT_CPU);
  assign aux_rvalid = rd_pend_q && (rd_tag_q == PORT_AUX);

  // Both ports see the RAM word; rvalid tells each whether it is theirs.
  assign cpu_rdata = ram_rdata;
  assign aux_rdata = ram_rdata;

endmodule : dm_port_arbiter
